// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: launches one FP16 add/subtract on an external core and
// returns its result. If the core stays silent for too long, the operation is
// aborted and a quiet-NaN timeout response is returned instead.
//
// Handshake rules, identical on both sides:
//   - A transfer happens on a rising clk edge where valid & ready are both 1.
//   - Request side: req_ready is high only in IDLE.
//   - Response side: rsp_valid is high only in RESP. While rsp_valid is high
//     and rsp_ready is low, the response fields are held stable.
//   - After a response transfer the sequencer returns to IDLE. It never
//     accepts a request in the same cycle as a response transfer.
module fpu_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_x,
    input  logic [15:0] req_y,
    input  logic        req_sub,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [1:0]  rsp_ofuf,
    output logic        rsp_timeout,
    output logic [15:0] core_x,
    output logic [15:0] core_y,
    output logic        core_addsub,
    output logic        core_reset,
    input  logic        core_done,
    input  logic [15:0] core_result,
    input  logic [1:0]  core_ofuf,
    output logic [15:0] ops_count,
    output logic [7:0]  timeout_count,
    output logic [1:0]  dbg_state
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   QNAN      = 16'h7E00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]   x_q, x_d;
    logic [15:0]   y_q, y_d;
    logic          sub_q, sub_d;
    logic [15:0]   result_q, result_d;
    logic [1:0]    ofuf_q, ofuf_d;
    logic          tmo_q, tmo_d;
    logic [15:0]   ops_q, ops_d;
    logic [7:0]    tmo_cnt_q, tmo_cnt_d;

    // State register and datapath registers. Reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            sub_q      <= 1'b0;
            result_q   <= '0;
            ofuf_q     <= '0;
            tmo_q      <= 1'b0;
            ops_q      <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sub_q      <= sub_d;
            result_q   <= result_d;
            ofuf_q     <= ofuf_d;
            tmo_q      <= tmo_d;
            ops_q      <= ops_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Next-state logic: accept, one load cycle, bounded wait, then hold the response.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        sub_d      = sub_q;
        result_d   = result_q;
        ofuf_d     = ofuf_q;
        tmo_d      = tmo_q;
        ops_d      = ops_q;
        tmo_cnt_d  = tmo_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    x_d     = req_x;
                    y_d     = req_y;
                    sub_d   = req_sub;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // The core is still held in reset here, so core_done means nothing yet.
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + CW'(1);
                // A completion in the last allowed cycle still counts as a completion.
                if (core_done) begin
                    result_d = core_result;
                    ofuf_d   = core_ofuf;
                    tmo_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    result_d = QNAN;
                    ofuf_d   = 2'b00;
                    tmo_d    = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    ops_d = ops_q + 16'd1;
                    if (tmo_q && (tmo_cnt_q != 8'hFF)) begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready     = (state_q == S_IDLE);
    assign rsp_valid     = (state_q == S_RESP);
    assign core_reset    = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign core_x        = x_q;
    assign core_y        = y_q;
    assign core_addsub   = sub_q;
    assign rsp_result    = result_q;
    assign rsp_ofuf      = ofuf_q;
    assign rsp_timeout   = tmo_q;
    assign ops_count     = ops_q;
    assign timeout_count = tmo_cnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer. It plays the role of the requester, the
// add/sub core and the response consumer. Inputs change 1 ns after a rising
// edge, and outputs are sampled at that same point.
module tb_fpu_op_sequencer;

    localparam int T = 64;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic        req_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_ofuf;
    logic        rsp_timeout;
    logic [15:0] core_x;
    logic [15:0] core_y;
    logic        core_addsub;
    logic        core_reset;
    logic        core_done;
    logic [15:0] core_result;
    logic [1:0]  core_ofuf;
    logic [15:0] ops_count;
    logic [7:0]  timeout_count;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int exp_ops = 0;
    int exp_tmo = 0;

    fpu_op_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_ofuf(rsp_ofuf), .rsp_timeout(rsp_timeout),
        .core_x(core_x), .core_y(core_y), .core_addsub(core_addsub),
        .core_reset(core_reset), .core_done(core_done),
        .core_result(core_result), .core_ofuf(core_ofuf),
        .ops_count(ops_count), .timeout_count(timeout_count),
        .dbg_state(dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Overall time limit.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_val("rst_req_ready", 32'(req_ready), 1);
        check_val("rst_rsp_valid", 32'(rsp_valid), 0);
        check_val("rst_rsp_result", 32'(rsp_result), 0);
        check_val("rst_rsp_ofuf", 32'(rsp_ofuf), 0);
        check_val("rst_rsp_timeout", 32'(rsp_timeout), 0);
        check_val("rst_core_x", 32'(core_x), 0);
        check_val("rst_core_y", 32'(core_y), 0);
        check_val("rst_core_addsub", 32'(core_addsub), 0);
        check_val("rst_core_reset", 32'(core_reset), 1);
        check_val("rst_ops_count", 32'(ops_count), 0);
        check_val("rst_timeout_count", 32'(timeout_count), 0);
    endtask

    // Present one request in IDLE and step through LOAD into the first WAIT cycle.
    task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic sub);
        req_valid = 1'b1;
        req_x = x;
        req_y = y;
        req_sub = sub;
        check_val("idle_req_ready", 32'(req_ready), 1);
        check_val("idle_core_reset", 32'(core_reset), 1);
        tick();
        req_valid = 1'b0;
        req_x = 16'hDEAD;
        req_y = 16'hBEEF;
        req_sub = ~sub;
        check_val("load_state", 32'(dbg_state), 32'(ST_LOAD));
        check_val("load_core_reset", 32'(core_reset), 1);
        check_val("load_req_ready", 32'(req_ready), 0);
        check_val("load_core_x", 32'(core_x), 32'(x));
        check_val("load_core_y", 32'(core_y), 32'(y));
        check_val("load_core_addsub", 32'(core_addsub), 32'(sub));
        tick();
        check_val("wait_state", 32'(dbg_state), 32'(ST_WAIT));
        check_val("wait_core_reset", 32'(core_reset), 0);
        check_val("wait_core_addsub", 32'(core_addsub), 32'(sub));
    endtask

    // Run the core model: done_at < 0 means the core never finishes.
    task automatic run_core(input int done_at, input logic [15:0] res, input logic [1:0] fl,
                            input int exp_cycles);
        int n = 0;
        core_result = 16'h1234;
        core_ofuf = 2'b11;
        while (!rsp_valid && n < 200) begin
            if (n == done_at) begin
                core_done = 1'b1;
                core_result = res;
                core_ofuf = fl;
            end
            tick();
            core_done = 1'b0;
            n++;
        end
        check_val("wait_cycles", 32'(n), 32'(exp_cycles));
    endtask

    // Check the response, hold it for bp cycles, then complete the handshake.
    task automatic finish_op(input logic [15:0] exp_res, input logic [1:0] exp_fl,
                             input logic exp_t, input logic [15:0] held_x, input int bp);
        check_val("rsp_valid", 32'(rsp_valid), 1);
        check_val("rsp_result", 32'(rsp_result), 32'(exp_res));
        check_val("rsp_ofuf", 32'(rsp_ofuf), 32'(exp_fl));
        check_val("rsp_timeout", 32'(rsp_timeout), 32'(exp_t));
        for (int k = 0; k < bp; k++) begin
            req_valid = 1'b1;
            req_x = 16'(k * 16'h0101);
            tick();
            check_val("bp_rsp_valid", 32'(rsp_valid), 1);
            check_val("bp_req_ready", 32'(req_ready), 0);
            check_val("bp_rsp_result", 32'(rsp_result), 32'(exp_res));
            check_val("bp_rsp_ofuf", 32'(rsp_ofuf), 32'(exp_fl));
            check_val("bp_rsp_timeout", 32'(rsp_timeout), 32'(exp_t));
            check_val("bp_core_x_held", 32'(core_x), 32'(held_x));
            check_val("bp_ops_count", 32'(ops_count), 32'(exp_ops));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_ops++;
        if (exp_t && exp_tmo < 255) exp_tmo++;
        check_val("hs_rsp_valid", 32'(rsp_valid), 0);
        check_val("hs_req_ready", 32'(req_ready), 1);
        check_val("hs_ops_count", 32'(ops_count), 32'(exp_ops));
        check_val("hs_timeout_count", 32'(timeout_count), 32'(exp_tmo));
        tick();
        check_val("post_ops_count", 32'(ops_count), 32'(exp_ops));
        check_val("post_state", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Main directed sequence.
    initial begin
        int pulses;
        reset = 1'b1;
        req_valid = 1'b0;
        req_x = '0;
        req_y = '0;
        req_sub = 1'b0;
        rsp_ready = 1'b0;
        core_done = 1'b0;
        core_result = '0;
        core_ofuf = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b0;
        tick();
        check_val("idle_after_reset", 32'(dbg_state), 32'(ST_IDLE));

        // Add: 1.0 + 1.0, core finishes in the fourth WAIT cycle.
        issue(16'h3C00, 16'h3C00, 1'b0);
        run_core(3, 16'h4000, 2'b00, 4);
        finish_op(16'h4000, 2'b00, 1'b0, 16'h3C00, 0);

        // Subtract: 2.0 - 1.0.
        issue(16'h4000, 16'h3C00, 1'b1);
        run_core(5, 16'h3C00, 2'b00, 6);
        finish_op(16'h3C00, 2'b00, 1'b0, 16'h4000, 0);

        // Timeout: the core never completes.
        issue(16'h3C00, 16'h4000, 1'b0);
        run_core(-1, 16'h0000, 2'b00, T);
        finish_op(16'h7E00, 2'b00, 1'b1, 16'h3C00, 0);

        // Backpressure for 10 cycles with overflow flags from the core.
        issue(16'h7BFF, 16'h7BFF, 1'b0);
        run_core(2, 16'h7C00, 2'b10, 3);
        finish_op(16'h7C00, 2'b10, 1'b0, 16'h7BFF, 10);

        // Done coincides with the last allowed WAIT cycle: completion wins.
        issue(16'h3555, 16'h0001, 1'b1);
        run_core(T - 1, 16'h3555, 2'b01, T);
        finish_op(16'h3555, 2'b01, 1'b0, 16'h3555, 0);

        // Done on the very first WAIT cycle.
        issue(16'h0400, 16'h8400, 1'b0);
        run_core(0, 16'h0000, 2'b01, 1);
        finish_op(16'h0000, 2'b01, 1'b0, 16'h0400, 2);

        // Reset mid-WAIT: everything clears immediately, and the dropped
        // operation never produces a response.
        issue(16'h4200, 16'h4400, 1'b1);
        repeat (5) tick();
        #1;
        reset = 1'b1;
        #1;
        exp_ops = 0;
        exp_tmo = 0;
        check_reset_values();
        @(posedge clk);
        #1;
        reset = 1'b0;
        core_done = 1'b1;
        core_result = 16'h4800;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rsp_valid) pulses++;
        end
        core_done = 1'b0;
        check_val("no_rsp_after_reset", 32'(pulses), 0);
        check_val("idle_after_midreset", 32'(dbg_state), 32'(ST_IDLE));

        // The sequencer recovers normally after reset.
        issue(16'h3C00, 16'h3800, 1'b0);
        run_core(1, 16'h3E00, 2'b00, 2);
        finish_op(16'h3E00, 2'b00, 1'b0, 16'h3C00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_op_sequencer.md
FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, is the maximum number of WAIT cycles allowed before an operation is aborted; legal range 2..1024.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  requester presents an operation.
REQ-005 req_ready  output  1  sequencer accepts an operation this cycle.
REQ-006 req_x  input  16  FP16 operand X (sign[15], exp[14:10], man[9:0]).
REQ-007 req_y  input  16  FP16 operand Y.
REQ-008 req_sub  input  1  0 = add, 1 = subtract.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer takes the response.
REQ-011 rsp_result  output  16  FP16 result.
REQ-012 rsp_ofuf  output  2  overflow/underflow flags from the core.
REQ-013 rsp_timeout  output  1  operation aborted by timeout.
REQ-014 core_x, core_y  output  16 each  operands to the add/sub core.
REQ-015 core_addsub  output  1  operation select to the core.
REQ-016 core_reset  output  1  core load/reset strobe; the core samples operands while this is high.
REQ-017 core_done  input  1  core completion flag.
REQ-018 core_result  input  16  core result.
REQ-019 core_ofuf  input  2  core flags.
REQ-020 ops_count  output  16  completed-response counter.
REQ-021 timeout_count  output  8  timed-out-response counter.

Function
REQ-022 States: IDLE, LOAD, WAIT, RESP. Reset state is IDLE.
REQ-023 req_ready shall be 1 only in IDLE. A request is accepted when req_valid & req_ready.
REQ-024 On accept, req_x, req_y and req_sub shall be registered into core_x, core_y and core_addsub, and the state shall go to LOAD.
REQ-025 Operand registers shall hold their values from accept until the next accept.
REQ-026 core_reset shall be 1 in IDLE and LOAD and 0 in WAIT and RESP, so the core sees new operands for at least one full cycle with reset high.
REQ-027 LOAD lasts exactly 1 cycle, then goes to WAIT; core_done is ignored in LOAD.
REQ-028 In WAIT, a wait counter starts at 0 and increments each cycle.
REQ-029 In WAIT with core_done = 1: capture core_result and core_ofuf, set rsp_timeout = 0, go to RESP.
REQ-030 In WAIT with core_done = 0 and the counter equal to TIMEOUT_CYCLES-1: set rsp_result = 16'h7E00, rsp_ofuf = 2'b00, rsp_timeout = 1, go to RESP.
REQ-031 If core_done = 1 and the timeout condition hold in the same cycle, core_done wins.
REQ-032 rsp_valid shall be 1 only in RESP. rsp_result, rsp_ofuf and rsp_timeout shall stay stable while rsp_valid & !rsp_ready.
REQ-033 On rsp_valid & rsp_ready, go to IDLE; no request is accepted in the same cycle, so the minimum issue interval is 4 cycles.
REQ-034 ops_count shall increment by 1 on every response handshake and wrap from 16'hFFFF to 0.
REQ-035 timeout_count shall increment on every handshake with rsp_timeout = 1 and saturate at 8'hFF.
REQ-036 Wait-counter width is clog2(TIMEOUT_CYCLES); the counter clears on entry to WAIT.

Reset
REQ-037 Asserting reset in any state shall immediately force: state IDLE, req_ready = 1, rsp_valid = 0, rsp_result = 0, rsp_ofuf = 0, rsp_timeout = 0, core_x = 0, core_y = 0, core_addsub = 0, core_reset = 1, ops_count = 0, timeout_count = 0, wait counter = 0.
REQ-038 An operation in flight when reset asserts shall be discarded, and no response shall be produced for it.

Verification
REQ-039 Add: req_x = 3C00, req_y = 3C00, req_sub = 0; core model asserts done 3 cycles into WAIT with result 4000 -> rsp_result = 4000, rsp_ofuf = 00, rsp_timeout = 0, ops_count = 1; core_reset high for LOAD.
REQ-040 Subtract: req_x = 4000, req_y = 3C00, req_sub = 1 -> core_addsub = 1 during WAIT; core returns 3C00 -> rsp_result = 3C00.
REQ-041 Timeout: core_done held at 0, TIMEOUT_CYCLES = 64 -> rsp_valid after 64 WAIT cycles; rsp_result = 7E00, rsp_timeout = 1, timeout_count = 1.
REQ-042 Backpressure: rsp_ready held at 0 for 10 cycles -> outputs stable, req_ready = 0 throughout, and a single handshake on release.
REQ-043 Race and reset: core_done coincides with the final timeout cycle -> rsp_timeout = 0. Reset asserted mid-WAIT -> all REQ-037 values, and no rsp_valid pulse afterwards.
